// File: rtl/peak_bin_finder.sv
// Scans one frame of magnitudes from a ping-pong RAM and publishes the peak bin,
// the bank it came from and a sticky done flag for the colour stage.
module peak_bin_finder #(
    parameter int SAMPLES   = 32,
    parameter int MAG_W     = 16,
    parameter int START_BIN = 1,
    localparam int AW       = $clog2(SAMPLES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ram_sel_in,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [AW-1:0]    rd_addr,
    input  logic [MAG_W-1:0] rd_data,
    output logic [AW-1:0]    index_holder,
    output logic             whichRAM,
    output logic             done,
    output logic             frame_done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [AW-1:0] FIRST_ADDR = AW'(START_BIN);
    localparam logic [AW-1:0] LAST_ADDR  = AW'(SAMPLES - 1);

    state_t            r_state;
    state_t            w_next;
    logic              r_bank;
    logic [AW-1:0]     r_addr;
    logic              r_vld;
    logic [AW-1:0]     r_idx;
    logic              r_first;
    logic [MAG_W-1:0]  r_best_mag;
    logic [AW-1:0]     r_best_idx;
    logic [AW-1:0]     r_index;
    logic              r_which;
    logic              r_done;
    logic              r_frame_done;
    logic              w_take;

    // Valid/ready contract on the read port: rd_data belongs to the address
    // presented with rd_en one cycle earlier; there is no back-pressure.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SCAN;
            S_SCAN:  if (r_addr == LAST_ADDR) w_next = S_DRAIN;
            S_DRAIN: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Strict compare keeps the lowest index on ties; first sample always loads.
    assign w_take = r_vld && (r_first || (rd_data > r_best_mag));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_bank       <= 1'b0;
            r_addr       <= '0;
            r_vld        <= 1'b0;
            r_idx        <= '0;
            r_first      <= 1'b0;
            r_best_mag   <= '0;
            r_best_idx   <= '0;
            r_index      <= '0;
            r_which      <= 1'b0;
            r_done       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_vld        <= (r_state == S_SCAN);
            r_idx        <= r_addr;
            r_frame_done <= 1'b0;

            if (w_take) begin
                r_best_mag <= rd_data;
                r_best_idx <= r_idx;
            end
            if (r_vld) r_first <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bank  <= ram_sel_in;
                        r_addr  <= FIRST_ADDR;
                        r_first <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (r_addr != LAST_ADDR) r_addr <= r_addr + AW'(1);
                end
                S_DRAIN: begin
                    // The last sample is still in flight, so commit from the live compare.
                    r_index      <= w_take ? r_idx : r_best_idx;
                    r_which      <= r_bank;
                    r_done       <= 1'b1;
                    r_frame_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign rd_en        = (r_state == S_SCAN);
    assign rd_bank      = r_bank;
    assign rd_addr      = r_addr;
    assign busy         = (r_state == S_SCAN) || (r_state == S_DRAIN);
    assign index_holder = r_index;
    assign whichRAM     = r_which;
    assign done         = r_done;
    assign frame_done   = r_frame_done;
    assign dbg_state    = r_state;

endmodule
